// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states and
// the byte-lane mask helper used by the lane aligner.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Byte lanes touched by an access of the given size at the given offset.
  // Only meaningful for aligned accesses; misaligned ones never reach memory.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] offset);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane handling: extract + sign/zero extend for loads, and
// merge of right-aligned store data into the old memory word for stores.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [2:0]  offset,
  input  logic [63:0] load_word,
  input  logic [63:0] old_word,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] merged
);

  logic [63:0] shifted;
  logic [63:0] wshift;
  logic [7:0]  mask;

  assign shifted = load_word >> {offset, 3'b000};
  assign wshift  = wdata << {offset, 3'b000};
  assign mask    = lane_mask(size, offset);

  // Extend the extracted lanes; doubleword ignores the unsigned flag.
  always_comb begin
    load_data = shifted;
    case (size)
      SZ_B:    load_data = {{56{~uns & shifted[7]}},  shifted[7:0]};
      SZ_H:    load_data = {{48{~uns & shifted[15]}}, shifted[15:0]};
      SZ_W:    load_data = {{32{~uns & shifted[31]}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  // Per-lane select between new store bytes and the old word.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign merged[8*gi +: 8] = mask[gi] ? wshift[8*gi +: 8] : old_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the execute stage and a 64-bit word memory.
// Owns the request latches, the access FSM, the bus tri-state and the
// response registers; lane extraction/merging lives in mem_lane_align.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_rw,
  output logic [63:0] mem_addr,
  inout  wire  [63:0] mem_data
);

  state_t      state;
  state_t      state_next;
  logic        req_err;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [2:0]  off_q;
  logic [63:0] wdata_q;
  logic [63:0] word_q;
  logic [63:0] load_data;
  logic [63:0] merged;

  // Misalignment or out-of-range word index for the incoming request.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SZ_H:    req_err = req_addr[0];
      SZ_W:    req_err = |req_addr[1:0];
      SZ_D:    req_err = |req_addr[2:0];
      default: req_err = 1'b0;
    endcase
    if (req_addr[63:3] >= 61'(WORDS)) req_err = 1'b1;
  end

  // Next-state: errors skip memory, dword stores need no read, others read first.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_err)                          state_next = ST_RESP;
          else if (req_we && req_size == SZ_D)  state_next = ST_WR;
          else                                  state_next = ST_RD;
        end
      end
      ST_RD:   state_next = we_q ? ST_WR : ST_RESP;
      ST_WR:   state_next = ST_RESP;
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus controls are pure state decodes so they settle right after posedge.
  assign req_ready = (state == ST_IDLE);
  assign mem_rw    = (state == ST_WR);
  assign mem_data  = mem_rw ? merged : 64'hz;

  // State register; reset drops any in-flight access before it can commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Request latches and the RD-phase word capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      size_q   <= SZ_B;
      uns_q    <= 1'b0;
      off_q    <= 3'd0;
      wdata_q  <= 64'd0;
      word_q   <= 64'd0;
      mem_addr <= 64'd0;
    end else begin
      if (state == ST_IDLE && req_valid) begin
        we_q     <= req_we;
        size_q   <= req_size;
        uns_q    <= req_unsigned;
        off_q    <= req_addr[2:0];
        wdata_q  <= req_wdata;
        mem_addr <= {3'b000, req_addr[63:3]};
      end
      if (state == ST_RD) word_q <= mem_data;
    end
  end

  // Response registers are loaded only on entry to RESP, cleared otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 64'd0;
    end else begin
      rsp_valid <= (state_next == ST_RESP);
      rsp_err   <= (state == ST_IDLE) && req_valid && req_err;
      rsp_rdata <= (state == ST_RD && !we_q) ? load_data : 64'd0;
    end
  end

  mem_lane_align u_align (
    .size      (size_q),
    .uns       (uns_q),
    .offset    (off_q),
    .load_word (mem_data),
    .old_word  (word_q),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios followed by
// randomized traffic checked against a byte-level reference model.
module tb_mem_access_unit;

  localparam int WORDS = 1024;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_rw;
  logic [63:0] mem_addr;
  wire  [63:0] mem_data;

  logic [63:0] mem       [0:WORDS-1];
  logic [63:0] model_mem [0:WORDS-1];
  logic        mem_oe;

  int n_asserts;
  int n_fail;

  mem_access_unit #(.WORDS(WORDS)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_rw       (mem_rw),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: drives reads whenever not in write mode, commits on negedge.
  assign mem_data = (!mem_rw && mem_oe) ? mem[mem_addr[9:0]] : 64'hz;

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = 64'd0;
    forever begin
      @(negedge clk);
      if (mem_rw) mem[mem_addr[9:0]] = mem_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from the access rules, updating model memory on stores.
  task automatic ref_model(input logic we, input logic [1:0] size, input logic uns,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           output logic err, output logic [63:0] rdata,
                           output int lat, output logic writes);
    int          nbytes;
    int          off;
    logic [63:0] idx;
    logic [63:0] v;
    logic [63:0] mask;
    nbytes = 1 << size;
    off    = int'(addr[2:0]);
    idx    = addr >> 3;
    err    = ((addr % 64'(nbytes)) != 64'd0) || (idx >= 64'(WORDS));
    rdata  = 64'd0;
    writes = 1'b0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      v = model_mem[idx[9:0]] >> (8 * off);
      if (nbytes < 8) begin
        mask = (64'd1 << (8 * nbytes)) - 64'd1;
        v = v & mask;
        if (!uns && v[8*nbytes-1]) v = v | ~mask;
      end
      rdata = v;
      lat   = 2;
    end else begin
      for (int b = 0; b < nbytes; b++)
        model_mem[idx[9:0]][8*(off+b) +: 8] = wdata[8*b +: 8];
      lat    = (nbytes == 8) ? 2 : 3;
      writes = 1'b1;
    end
  endtask

  // One complete transaction: drive, wait for the pulse, compare everything.
  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                        output logic [63:0] got_rdata);
    logic        exp_err;
    logic [63:0] exp_rdata;
    int          exp_lat;
    logic        exp_write;
    int          lat;
    logic        got;
    logic        saw_write;
    logic        busy_ok;
    ref_model(we, size, uns, addr, wdata, exp_err, exp_rdata, exp_lat, exp_write);
    @(negedge clk);
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    lat = 0; got = 1'b0; saw_write = 1'b0; busy_ok = 1'b1;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (lat == 1) req_valid = 1'b0;
      if (mem_rw) saw_write = 1'b1;
      if (req_ready) busy_ok = 1'b0;
      if (rsp_valid) got = 1'b1;
    end
    got_rdata = rsp_rdata;
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_err"}, 64'(rsp_err), 64'(exp_err));
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_wr"}, 64'(saw_write), 64'(exp_write));
    check({tag, "_busy"}, 64'(busy_ok), 64'd1);
    @(negedge clk);
    check({tag, "_pulse"}, {62'd0, rsp_valid, req_ready}, 64'd1);
    if (exp_write) check({tag, "_mem"}, mem[addr[12:3]], model_mem[addr[12:3]]);
    $display("txn %s we=%0d size=%0d uns=%0d addr=%h wdata=%h -> err=%0d rdata=%h lat=%0d",
             tag, we, size, uns, addr, wdata, rsp_err, got_rdata, lat);
  endtask

  logic [63:0] rd;
  logic        released;
  logic        any_rsp;
  int          acc_n;
  int          last_acc;
  int          pulses;
  logic [63:0] exp_b2b;

  initial begin
    n_asserts = 0; n_fail = 0;
    for (int i = 0; i < WORDS; i++) model_mem[i] = 64'd0;
    mem_oe = 1'b1;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_rsp", {62'd0, rsp_valid, rsp_err}, 64'd0);
    check("rst_rdata", rsp_rdata, 64'd0);
    check("rst_mem_rw", 64'(mem_rw), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    rst = 1'b0;

    // Doubleword store and load back
    do_req("st_d", 1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788, rd);
    check("st_d_word2", mem[2], 64'h1122334455667788);
    do_req("ld_d", 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, rd);
    check("ld_d_val", rd, 64'h1122334455667788);

    // Byte read-modify-write
    do_req("st_b", 1'b1, 2'd0, 1'b0, 64'h13, 64'hFFFF_FFFF_FFFF_FFAB, rd);
    check("st_b_word2", mem[2], 64'h11223344AB667788);

    // Load extension
    do_req("ld_bs", 1'b0, 2'd0, 1'b0, 64'h13, 64'd0, rd);
    check("ld_bs_val", rd, 64'hFFFFFFFFFFFFFFAB);
    do_req("ld_bu", 1'b0, 2'd0, 1'b1, 64'h13, 64'd0, rd);
    check("ld_bu_val", rd, 64'h00000000000000AB);
    do_req("ld_hs", 1'b0, 2'd1, 1'b0, 64'h12, 64'd0, rd);
    check("ld_hs_val", rd, 64'hFFFFFFFFFFFFAB66);

    // Errors
    do_req("err_mis", 1'b0, 2'd2, 1'b0, 64'h12, 64'd0, rd);
    do_req("err_rng", 1'b0, 2'd3, 1'b0, 64'h2000, 64'd0, rd);

    // Bus released while idle
    @(negedge clk);
    mem_oe = 1'b0;
    #1;
    released = (mem_data === 64'hz) || (mem_data === 64'h0);
    check("bus_idle_z", 64'(released), 64'd1);
    mem_oe = 1'b1;

    // Back-to-back loads with req_valid held high
    exp_b2b = model_mem[2];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
    req_addr = 64'h10; req_wdata = 64'd0;
    acc_n = 0; last_acc = 0; pulses = 0;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      if (req_ready) begin
        if (acc_n > 0) check("b2b_gap", 64'(c - last_acc), 64'd3);
        last_acc = c;
        acc_n++;
      end
      if (rsp_valid) begin
        pulses++;
        check("b2b_rdata", rsp_rdata, exp_b2b);
      end
    end
    req_valid = 1'b0;
    check("b2b_acc", 64'(acc_n), 64'd3);
    check("b2b_pulses", 64'(pulses), 64'd3);
    $display("txn b2b accepts=%0d pulses=%0d", acc_n, pulses);
    @(negedge clk);

    // Reset in the RD phase of a byte store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 64'h15; req_wdata = 64'hCD;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rmw_rst_ready", 64'(req_ready), 64'd1);
    check("rmw_rst_mem_rw", 64'(mem_rw), 64'd0);
    check("rmw_rst_rsp", {62'd0, rsp_valid, rsp_err}, 64'd0);
    mem_oe = 1'b0;
    #1;
    released = (mem_data === 64'hz) || (mem_data === 64'h0);
    check("rmw_rst_bus_z", 64'(released), 64'd1);
    mem_oe = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    any_rsp = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) any_rsp = 1'b1;
    end
    check("rmw_rst_no_rsp", 64'(any_rsp), 64'd0);
    check("rmw_rst_word", mem[2], model_mem[2]);
    $display("txn rmw_reset word2=%h", mem[2]);

    // Randomized traffic against the reference model
    for (int t = 0; t < 80; t++) begin
      logic        r_we;
      logic [1:0]  r_size;
      logic        r_uns;
      logic [63:0] r_idx;
      logic [63:0] r_addr;
      logic [63:0] r_wdata;
      r_we    = 1'($urandom_range(0, 1));
      r_size  = 2'($urandom_range(0, 3));
      r_uns   = 1'($urandom_range(0, 1));
      r_idx   = ($urandom_range(0, 9) == 0) ? 64'(WORDS + $urandom_range(0, 100))
                                            : 64'($urandom_range(0, 7));
      r_addr  = (r_idx << 3) | 64'($urandom_range(0, 7));
      r_wdata = {32'($urandom), 32'($urandom)};
      do_req("rand", r_we, r_size, r_uns, r_addr, r_wdata, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
